decryptor: RTL and testbench
============================

# decryptor

Iterative AES-128 decryption core; inverse of the team's `encryptor`, which runs the forward cipher. Accepts a 128-bit ciphertext and the original 128-bit cipher key, derives round key 10 by forward expansion, then runs the inverse cipher one round per clock, regenerating round keys backwards on the fly. It sits beside `encryptor` so the design can round-trip data: the same key recovers the original plaintext.

## Interface
- No parameters: key size is fixed at 128 bits, 10 rounds.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-low; sampled at the rising edge of `clk`.
- `start` input 1: request strobe; sampled only in IDLE.
- `ciphertext` input 128: block to decrypt; captured on an accepted `start`.
- `key` input 128: cipher key, the same value used for encryption; captured on an accepted `start`.
- `plaintext` output 128: registered result; held until the next completion.
- `done` output 1: one-cycle pulse; `plaintext` is valid and new in that cycle.
- `busy` output 1: high from the cycle after an accepted `start` until `done` asserts.

## Operation
- Byte order follows FIPS-197. Byte 0 is bits [127:120]. The state matrix is column-major: byte i maps to row i%4, column i/4.
- FSM states: IDLE, KEYEXP, ADDK, ROUND.
- **IDLE**
  - On `start`=1: capture `ciphertext` into the state register and `key` into the key register.
  - Set rcon=0x01 and the 4-bit counter to 0, then go to KEYEXP.
  - On `start`=0: no state change.
- **KEYEXP** (10 cycles)
  - Each cycle, replace the key register with the next forward round key: RotWord, SubWord, rcon XOR on word 0, then chained XOR.
  - rcon advances by xtime each cycle: 01,02,04,08,10,20,40,80,1B,36.
  - After 10 cycles the key register holds K10. Go to ADDK.
- **ADDK** (1 cycle)
  - state ← state ^ K10.
  - Set rcon=0x36 and the counter to 9, then go to ROUND.
- **ROUND** (10 cycles, counter 9 down to 0)
  - Compute the previous round key combinationally from the key register with the inverse schedule:
    - w[i] = w[i+4] ^ w[i+3] for words 1..3.
    - w0 = w4 ^ SubWord(RotWord(w3')) ^ rcon.
  - state ← InvShiftRows, then InvSubBytes, then AddRoundKey(prev key), then InvMixColumns.
  - InvMixColumns is omitted when counter=0.
  - Key register ← prev key. rcon steps back one entry: inverse xtime, 0x36 → 0x1B → … → 0x01.
  - When counter=0: load `plaintext` with the round output, pulse `done`, clear `busy`, go to IDLE.
- SubBytes and InvSubBytes are 256-entry combinational lookup functions.
- GF(2^8) multiplies by 9, B, D and E use the reduction polynomial 0x11B.
- `start` while busy is ignored; it is not queued.
- `ciphertext` and `key` may change freely after acceptance.
- `start` in the same cycle as `done` is ignored, because the FSM is not yet in IDLE. Back-to-back operation needs one idle cycle.

## Timing
- Reset (`rst`=0 at an edge):
  - FSM → IDLE.
  - `plaintext` = 0, `done` = 0, `busy` = 0.
  - Internal state, key and rcon registers are cleared.
- Reset mid-operation aborts the operation: no `done`, and `plaintext` returns to 0.
- Latency: with `start` accepted at edge E0, `done` and a valid `plaintext` appear after edge E21, i.e. 21 cycles.
  - E1–E10: key expansion.
  - E11: ADDK.
  - E12–E21: rounds.
- `busy` is high for the 21 cycles after E0 and drops in the same cycle `done` rises.
- Throughput: one block per 22 cycles.
- `done` is exactly one cycle wide.
- `plaintext` changes only at `done` or at reset.

## Test plan
- FIPS-197 Appendix C.1: key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a → `plaintext` 00112233445566778899aabbccddeeff, `done` exactly 21 cycles after `start`.
- FIPS-197 Appendix B: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32 → 3243f6a8885a308d313198a2e0370734.
  - The internal key register must equal d014f9a8c9ee2589e13f0cc8b6630ca6 in the ADDK cycle.
- Pulse `start` at cycles 5 and 10 of an operation, and change `ciphertext` and `key` mid-run → the result matches the originally captured inputs; exactly one `done`.
- Assert `rst`=0 at cycle 15 of an operation → no `done`, `busy`=0, `plaintext`=0.
  - A following C.1 request completes correctly.
- Round-trip: feed `encryptor` output for 100 random key/plaintext pairs → decrypted `plaintext` equals the original.
  - Hold `start` high continuously → one operation per 22 cycles.

Source files
------------

// File: rtl/decryptor.sv
// rtl/decryptor.sv - iterative AES-128 decryption core, one inverse round per clock
module decryptor (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic [127:0] plaintext,
  output logic         done,
  output logic         busy
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, KEYEXP, ADDK, ROUND} fsm_t;

  fsm_t         fsm, fsm_n;
  logic [127:0] st, st_n, key_r, key_n, pt_n;
  logic [7:0]   rcon, rcon_n;
  logic [3:0]   cnt, cnt_n;
  logic         done_n, busy_n;

  // Table entry b sits at bits {~b,3'b111} down to {~b,3'b000} of the packed constant.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] a);
    return a[0] ? ({1'b0, a[7:1]} ^ 8'h8d) : {1'b0, a[7:1]};
  endfunction

  // Multiply by a 4-bit constant m (9, B, D, E) as a sum of a, 2a, 4a, 8a.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (m[3] ? x8 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[0] ? a : 8'h00);
  endfunction

  logic [31:0]  f0, f1, f2, f3, p0, p1, p2, p3;
  logic [127:0] key_fwd, key_prev, ark, mixed, round_out;

  always_comb begin
    f0 = key_r[127:96] ^ sub_rot(key_r[31:0]) ^ {rcon, 24'h0};
    f1 = key_r[95:64] ^ f0;
    f2 = key_r[63:32] ^ f1;
    f3 = key_r[31:0]  ^ f2;
    key_fwd = {f0, f1, f2, f3};
    p3 = key_r[31:0]  ^ key_r[63:32];
    p2 = key_r[63:32] ^ key_r[95:64];
    p1 = key_r[95:64] ^ key_r[127:96];
    p0 = key_r[127:96] ^ sub_rot(p3) ^ {rcon, 24'h0};
    key_prev = {p0, p1, p2, p3};
  end

  // InvShiftRows folded into the byte wiring: row r of column c comes from column (c-r) mod 4.
  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int SRC = (i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4);
    assign ark[127-8*i -: 8] = inv_sbox(st[127-8*SRC -: 8]) ^ key_prev[127-8*i -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = ark[127-32*c -: 8];
    assign a1 = ark[119-32*c -: 8];
    assign a2 = ark[111-32*c -: 8];
    assign a3 = ark[103-32*c -: 8];
    assign mixed[127-32*c -: 32] = {
      gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
      gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
      gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
      gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)
    };
  end

  assign round_out = (cnt == 4'd0) ? ark : mixed;

  always_comb begin
    fsm_n  = fsm;
    st_n   = st;
    key_n  = key_r;
    rcon_n = rcon;
    cnt_n  = cnt;
    pt_n   = plaintext;
    done_n = 1'b0;
    busy_n = busy;
    unique case (fsm)
      IDLE: begin
        if (start) begin
          st_n   = ciphertext;
          key_n  = key;
          rcon_n = 8'h01;
          cnt_n  = 4'd0;
          busy_n = 1'b1;
          fsm_n  = KEYEXP;
        end
      end
      KEYEXP: begin
        key_n  = key_fwd;
        rcon_n = xtime(rcon);
        cnt_n  = cnt + 4'd1;
        if (cnt == 4'd9) fsm_n = ADDK;
      end
      ADDK: begin
        st_n   = st ^ key_r;
        rcon_n = 8'h36;
        cnt_n  = 4'd9;
        fsm_n  = ROUND;
      end
      ROUND: begin
        st_n   = round_out;
        key_n  = key_prev;
        rcon_n = inv_xtime(rcon);
        cnt_n  = cnt - 4'd1;
        if (cnt == 4'd0) begin
          cnt_n  = 4'd0;
          pt_n   = round_out;
          done_n = 1'b1;
          busy_n = 1'b0;
          fsm_n  = IDLE;
        end
      end
      default: fsm_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm       <= IDLE;
      st        <= '0;
      key_r     <= '0;
      rcon      <= '0;
      cnt       <= '0;
      plaintext <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      fsm       <= fsm_n;
      st        <= st_n;
      key_r     <= key_n;
      rcon      <= rcon_n;
      cnt       <= cnt_n;
      plaintext <= pt_n;
      done      <= done_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_decryptor.sv
// tb/tb_decryptor.sv - self-checking bench for decryptor: vector table, corner sequences, random round-trip
module tb_decryptor;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] ciphertext = '0;
  logic [127:0] key = '0;
  logic [127:0] plaintext;
  logic         done, busy;

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] rk [11];

  decryptor dut (
    .clk(clk), .rst(rst), .start(start), .ciphertext(ciphertext), .key(key),
    .plaintext(plaintext), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box built from its definition: multiplicative inverse then the affine map.
  function automatic void init_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      sbox_m[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  function automatic void expand_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] k, input logic [127:0] p);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] v;
    expand_key(k);
    v = p ^ rk[0];
    for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_m[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[4*c+r] = (rnd == 10) ? t[4*c+r] :
                     gmul(t[4*c+r], 8'h02) ^ gmul(t[4*c+(r+1)%4], 8'h03) ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
      v = rk[rnd];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ v[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
    return v;
  endfunction

  task automatic run_op(input logic [127:0] k, input logic [127:0] c, output logic [127:0] res,
                        output int lat, output logic [127:0] k_addk, output logic proto_ok);
    key = k;
    ciphertext = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    proto_ok = busy;
    lat = -1;
    k_addk = '0;
    res = '0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 10) k_addk = dut.key_r;
      if (done) begin
        lat = cyc;
        res = plaintext;
        if (busy) proto_ok = 1'b0;
        break;
      end
      if (!busy) proto_ok = 1'b0;
    end
    @(posedge clk); #1;
    if (done) proto_ok = 1'b0;
  endtask

  typedef struct {
    logic [127:0] k;
    logic [127:0] ct;
    logic [127:0] pt;
    logic [127:0] k10;
  } vec_t;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    vec_t         tv [3];
    logic [127:0] res, ka, k, p, c;
    int           lat, n_done, t_prev, rt_bad;
    logic         pok, iv_ok, all_ok;

    init_sbox();
    tv[0] = '{C1_KEY, C1_CT, C1_PT, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    tv[1] = '{B_KEY, B_CT, B_PT, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    expand_key(128'h0);
    tv[2] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, rk[10]};

    repeat (3) @(posedge clk);
    #1;
    check("reset_plaintext", plaintext, 128'h0);
    check("reset_done", 128'(done), 128'h0);
    check("reset_busy", 128'(busy), 128'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      run_op(tv[i].k, tv[i].ct, res, lat, ka, pok);
      check($sformatf("vec%0d_plaintext", i), res, tv[i].pt);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'(21));
      check($sformatf("vec%0d_busy_done", i), 128'(pok), 128'h1);
      check($sformatf("vec%0d_key_addk", i), ka, tv[i].k10);
    end

    // Extra start pulses and changing inputs while busy must not disturb the run.
    key = C1_KEY;
    ciphertext = C1_CT;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_done = 0;
    res = '0;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == 5 || cyc == 10);
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      ciphertext = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (done) begin
        n_done++;
        res = plaintext;
      end
    end
    start = 1'b0;
    check("midrun_done_count", 128'(n_done), 128'(1));
    check("midrun_plaintext", res, C1_PT);
    check("midrun_idle_busy", 128'(busy), 128'h0);

    // Reset in the middle of a run aborts it.
    key = C1_KEY;
    ciphertext = C1_CT;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 128'(busy), 128'h0);
    check("abort_plaintext", plaintext, 128'h0);
    check("abort_done", 128'(done), 128'h0);
    rst = 1'b1;
    n_done = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("abort_no_done", 128'(n_done), 128'h0);
    run_op(C1_KEY, C1_CT, res, lat, ka, pok);
    check("after_abort_plaintext", res, C1_PT);
    check("after_abort_latency", 128'(lat), 128'(21));

    rt_bad = 0;
    for (int n = 0; n < 100; n++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      p = {$urandom(), $urandom(), $urandom(), $urandom()};
      c = ref_encrypt(k, p);
      run_op(k, c, res, lat, ka, pok);
      check($sformatf("roundtrip_%0d", n), res, p);
      if (lat != 21 || !pok) rt_bad++;
    end
    check("roundtrip_timing_errors", 128'(rt_bad), 128'h0);

    // start held high: a new block every 22 cycles.
    key = B_KEY;
    ciphertext = B_CT;
    start = 1'b1;
    n_done = 0;
    t_prev = 0;
    iv_ok = 1'b1;
    all_ok = 1'b1;
    for (int cyc = 1; cyc <= 120 && n_done < 3; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        if (plaintext !== B_PT) all_ok = 1'b0;
        if (n_done == 0 && cyc != 22) iv_ok = 1'b0;
        if (n_done > 0 && cyc - t_prev != 22) iv_ok = 1'b0;
        t_prev = cyc;
        n_done++;
        if (n_done == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("stream_done_count", 128'(n_done), 128'(3));
    check("stream_interval", 128'(iv_ok), 128'h1);
    check("stream_plaintext", 128'(all_ok), 128'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
